// File: rtl/md_pkg.sv
// md_pkg: shared types and default latencies for the multiply/divide unit.
// Holds the opt encoding, FSM state enum and latency constants.
package md_pkg;

  typedef enum logic [2:0] {
    OPT_MULT  = 3'b000,
    OPT_MULTU = 3'b001,
    OPT_DIV   = 3'b010,
    OPT_DIVU  = 3'b011,
    OPT_MTHI  = 3'b100,
    OPT_MTLO  = 3'b101,
    OPT_MADD  = 3'b110,
    OPT_MSUB  = 3'b111
  } md_opt_e;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } md_state_e;

  localparam int MD_MULT_CYCLES = 5;
  localparam int MD_DIV_CYCLES  = 10;

endpackage

// File: rtl/md_divider.sv
// md_divider: combinational 32-bit signed/unsigned divide.
// Ports: dividend, divisor, isSigned in; quotient, remainder, div_zero out.
module md_divider (
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  input  logic        isSigned,
  output logic [31:0] quotient,
  output logic [31:0] remainder,
  output logic        div_zero
);

  logic        negA;
  logic        negB;
  logic [31:0] magA;
  logic [31:0] magB;
  logic [31:0] safeB;
  logic [31:0] uq;
  logic [31:0] ur;

  // Divide magnitudes, then restore signs: quotient truncates
  // toward zero, remainder follows the dividend. The 0x80000000
  // magnitude is representable unsigned, so -2^31 / -1 wraps
  // back to 0x80000000 naturally.
  assign negA  = isSigned & dividend[31];
  assign negB  = isSigned & divisor[31];
  assign magA  = negA ? -dividend : dividend;
  assign magB  = negB ? -divisor : divisor;
  assign div_zero = (divisor == 32'd0);
  assign safeB = div_zero ? 32'd1 : magB;
  assign uq    = magA / safeB;
  assign ur    = magA % safeB;

  assign quotient  = (negA ^ negB) ? -uq : uq;
  assign remainder = negA ? -ur : ur;

endmodule

// File: rtl/md_unit.sv
// md_unit: multi-cycle MIPS mult/div unit owning HI/LO.
// Ports: clk, reset, v1, v2, opt, start in; busy, hi, lo out.
// MD_ACC_EN enables madd/msub (opt 110/111); otherwise they are no-ops.
module md_unit
  import md_pkg::*;
#(
  parameter int MULT_CYCLES = MD_MULT_CYCLES,
  parameter int DIV_CYCLES  = MD_DIV_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] v1,
  input  logic [31:0] v2,
  input  logic [2:0]  opt,
  input  logic        start,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MaxC =
    (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MaxC + 1);

  md_state_e   state;
  md_state_e   stateNext;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cntNext;
  md_opt_e     opReg;
  logic [31:0] opA;
  logic [31:0] opB;
  logic [31:0] hiReg;
  logic [31:0] loReg;
  logic [31:0] hiNext;
  logic [31:0] loNext;
  logic        load;

  logic isMul;
  logic isDiv;
  logic isMt;
  logic isAcc;
  logic runOp;

  logic signed [63:0] sA;
  logic signed [63:0] sB;
  logic [63:0] prodS;
  logic [63:0] prodU;
  logic [63:0] res;
  logic        resWe;

  logic [31:0] quo;
  logic [31:0] rem;
  logic        divZero;

  md_divider uDiv (
    .dividend  (opA),
    .divisor   (opB),
    .isSigned  (opReg == OPT_DIV),
    .quotient  (quo),
    .remainder (rem),
    .div_zero  (divZero)
  );

  always_comb begin
    isMul = 1'b0;
    isDiv = 1'b0;
    isMt  = 1'b0;
    isAcc = 1'b0;
    unique case (1'b1)
      opt[2:1] == 2'b00: isMul = 1'b1;
      opt[2:1] == 2'b01: isDiv = 1'b1;
      opt[2:1] == 2'b10: isMt  = 1'b1;
      default:           isAcc = 1'b1;
    endcase
  end

`ifdef MD_ACC_EN
  assign runOp = isMul | isDiv | isAcc;
`else
  assign runOp = isMul | isDiv;
`endif

  assign sA    = {{32{opA[31]}}, opA};
  assign sB    = {{32{opB[31]}}, opB};
  assign prodS = sA * sB;
  assign prodU = {32'd0, opA} * {32'd0, opB};

  // Result is built from latched operands and, for madd/msub,
  // from HI/LO as they stand on the commit cycle.
  always_comb begin
    res   = prodS;
    resWe = 1'b1;
    unique case (opReg)
      OPT_MULT:  res = prodS;
      OPT_MULTU: res = prodU;
      OPT_DIV,
      OPT_DIVU: begin
        res   = {rem, quo};
        resWe = ~divZero;
      end
`ifdef MD_ACC_EN
      OPT_MADD:  res = {hiReg, loReg} + prodS;
      OPT_MSUB:  res = {hiReg, loReg} - prodS;
`endif
      default:   resWe = 1'b0;
    endcase
  end

  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    hiNext    = hiReg;
    loNext    = loReg;
    load      = 1'b0;
    unique case (state)
      IDLE: begin
        if (start && isMt) begin
          if (opt[0]) loNext = v1;
          else        hiNext = v1;
        end else if (start && runOp) begin
          load      = 1'b1;
          stateNext = RUN;
          cntNext   = isDiv ? CW'(DIV_CYCLES)
                            : CW'(MULT_CYCLES);
        end
      end
      RUN: begin
        cntNext = cnt - CW'(1);
        if (cnt == CW'(1)) begin
          stateNext = IDLE;
          if (resWe) begin
            hiNext = res[63:32];
            loNext = res[31:0];
          end
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      hiReg <= '0;
      loReg <= '0;
      opReg <= OPT_MULT;
      opA   <= '0;
      opB   <= '0;
    end else begin
      state <= stateNext;
      cnt   <= cntNext;
      hiReg <= hiNext;
      loReg <= loNext;
      if (load) begin
        opReg <= md_opt_e'(opt);
        opA   <= v1;
        opB   <= v2;
      end
    end
  end

  assign busy = (state == RUN);
  assign hi   = hiReg;
  assign lo   = loReg;

endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: directed and random checks of md_unit against
// an arithmetic model of MIPS HI/LO semantics.
module tb_md_unit;
  import md_pkg::*;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk;
  logic        reset;
  logic [31:0] v1;
  logic [31:0] v2;
  logic [2:0]  opt;
  logic        start;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks = 0;
  int errors = 0;
  logic [31:0] mHi;
  logic [31:0] mLo;

  md_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk   (clk),
    .reset (reset),
    .v1    (v1),
    .v2    (v2),
    .opt   (opt),
    .start (start),
    .busy  (busy),
    .hi    (hi),
    .lo    (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int latency(input logic [2:0] op);
    if (op[2:1] == 2'b00) return MC;
    if (op[2:1] == 2'b01) return DC;
`ifdef MD_ACC_EN
    if (op[2:1] == 2'b11) return MC;
`endif
    return 0;
  endfunction

  function automatic void model(input logic [2:0] op,
                                input logic [31:0] a,
                                input logic [31:0] b);
    longint sa;
    longint sb;
    logic [63:0] acc;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    acc = {mHi, mLo};
    case (op)
      3'b000: {mHi, mLo} = 64'(sa * sb);
      3'b001: {mHi, mLo} = {32'd0, a} * {32'd0, b};
      3'b010: if (b != 0) begin
        mLo = 32'(sa / sb);
        mHi = 32'(sa % sb);
      end
      3'b011: if (b != 0) begin
        mLo = a / b;
        mHi = a % b;
      end
      3'b100: mHi = a;
      3'b101: mLo = a;
`ifdef MD_ACC_EN
      3'b110: {mHi, mLo} = acc + 64'(sa * sb);
      3'b111: {mHi, mLo} = acc - 64'(sa * sb);
`endif
      default: ;
    endcase
  endfunction

  // Called at a negedge; issues the op in that cycle (T) and
  // returns at the negedge of T+N+1 after checking busy and HI/LO.
  task automatic run(input string tag, input logic [2:0] op,
                     input logic [31:0] a, input logic [31:0] b);
    int n;
    n = latency(op);
    start = 1'b1;
    opt   = op;
    v1    = a;
    v2    = b;
    @(negedge clk);
    start = 1'b0;
    model(op, a, b);
    for (int i = 0; i < n; i++) begin
      check({tag, " busy"}, {31'd0, busy}, 32'd1);
      @(negedge clk);
    end
    check({tag, " idle"}, {31'd0, busy}, 32'd0);
    check({tag, " hi"}, hi, mHi);
    check({tag, " lo"}, lo, mLo);
  endtask

  function automatic logic [31:0] pick();
    logic [31:0] c [6];
    c[0] = 32'h8000_0000;
    c[1] = 32'hFFFF_FFFF;
    c[2] = 32'h0000_0000;
    c[3] = 32'h7FFF_FFFF;
    c[4] = 32'h0000_0001;
    c[5] = 32'hFFFF_FFFE;
    if ($urandom_range(0, 3) == 0) return c[$urandom_range(0, 5)];
    return $urandom;
  endfunction

  initial begin
    reset = 1'b1;
    start = 1'b0;
    opt   = 3'b000;
    v1    = '0;
    v2    = '0;
    mHi   = '0;
    mLo   = '0;
    repeat (2) @(negedge clk);
    check("rst busy", {31'd0, busy}, 32'd0);
    check("rst hi", hi, 32'd0);
    check("rst lo", lo, 32'd0);
    reset = 1'b0;

    run("mult", 3'b000, 32'hFFFF_FFFE, 32'd3);
    check("mult hi k", hi, 32'hFFFF_FFFF);
    check("mult lo k", lo, 32'hFFFF_FFFA);
    run("multu", 3'b001, 32'hFFFF_FFFE, 32'd3);
    check("multu hi k", hi, 32'h0000_0002);
    check("multu lo k", lo, 32'hFFFF_FFFA);
    run("divu", 3'b011, 32'd7, 32'd2);
    check("divu lo k", lo, 32'd3);
    check("divu hi k", hi, 32'd1);
    run("div", 3'b010, 32'hFFFF_FFF9, 32'd2);
    check("div lo k", lo, 32'hFFFF_FFFD);
    check("div hi k", hi, 32'hFFFF_FFFF);
    run("div0", 3'b010, 32'd1234, 32'd0);
    check("div0 hi k", hi, 32'hFFFF_FFFF);
    check("div0 lo k", lo, 32'hFFFF_FFFD);
    run("divovf", 3'b010, 32'h8000_0000, 32'hFFFF_FFFF);
    check("divovf lo k", lo, 32'h8000_0000);
    check("divovf hi k", hi, 32'd0);

    // mthi then mtlo in consecutive cycles
    start = 1'b1;
    opt   = 3'b100;
    v1    = 32'h1234_5678;
    @(negedge clk);
    check("mthi hi", hi, 32'h1234_5678);
    check("mthi busy", {31'd0, busy}, 32'd0);
    opt = 3'b101;
    v1  = 32'h9ABC_DEF0;
    @(negedge clk);
    start = 1'b0;
    mHi = 32'h1234_5678;
    mLo = 32'h9ABC_DEF0;
    check("mtlo lo", lo, 32'h9ABC_DEF0);
    check("mtlo hi", hi, 32'h1234_5678);
    check("mtlo busy", {31'd0, busy}, 32'd0);

    // start while running is ignored
    start = 1'b1;
    opt   = 3'b000;
    v1    = 32'd5;
    v2    = 32'd7;
    @(negedge clk);
    start = 1'b0;
    model(3'b000, 32'd5, 32'd7);
    @(negedge clk);
    start = 1'b1;
    opt   = 3'b011;
    v1    = 32'd100;
    v2    = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("ign busy", {31'd0, busy}, 32'd0);
    check("ign hi", hi, 32'd0);
    check("ign lo", lo, 32'd35);
    @(negedge clk);
    check("ign nostart", {31'd0, busy}, 32'd0);
    check("ign lo2", lo, 32'd35);

`ifdef MD_ACC_EN
    run("acc mthi", 3'b100, 32'd0, 32'd0);
    run("acc mtlo", 3'b101, 32'hFFFF_FFFF, 32'd0);
    run("madd", 3'b110, 32'd1, 32'd1);
    check("madd hi k", hi, 32'd1);
    check("madd lo k", lo, 32'd0);
    run("msub", 3'b111, 32'd1, 32'd1);
    check("msub hi k", hi, 32'd0);
    check("msub lo k", lo, 32'hFFFF_FFFF);
`else
    run("nop mthi", 3'b100, 32'd1, 32'd0);
    run("nop mtlo", 3'b101, 32'd0, 32'd0);
    run("nop madd", 3'b110, 32'd1, 32'd1);
    check("nop hi k", hi, 32'd1);
    check("nop lo k", lo, 32'd0);
    run("nop msub", 3'b111, 32'd9, 32'd9);
`endif

    for (int k = 0; k < 40; k++) begin
      logic [2:0]  rop;
      logic [31:0] ra;
      logic [31:0] rb;
      rop = 3'($urandom_range(0, 7));
      ra  = pick();
      rb  = ($urandom_range(0, 7) == 0) ? 32'd0 : pick();
      run("rand", rop, ra, rb);
    end

    // reset in the middle of a div
    run("pre", 3'b100, 32'hCAFE_0001, 32'd0);
    start = 1'b1;
    opt   = 3'b010;
    v1    = 32'd1000;
    v2    = 32'd7;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mrst busy", {31'd0, busy}, 32'd0);
    check("mrst hi", hi, 32'd0);
    check("mrst lo", lo, 32'd0);
    repeat (12) @(negedge clk);
    check("mrst late busy", {31'd0, busy}, 32'd0);
    check("mrst late hi", hi, 32'd0);
    check("mrst late lo", lo, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/md_unit.md
# md_unit

Multi-cycle multiply/divide unit with HI/LO registers, instantiated in the Execute stage of the 5-stage MIPS pipeline. It accepts an operation pulse from E together with the forwarded rs/rt values and models fixed MIPS latencies. It exposes `busy` so the hazard unit can stall any HI/LO-using instruction in D while the unit is occupied. HI/LO are read combinationally by mfhi/mflo in E.

## Interface
- `MULT_CYCLES`, default 5: busy cycles for mult/multu (and madd/msub when enabled); must be ≥1.
- `DIV_CYCLES`, default 10: busy cycles for div/divu; must be ≥1.
- `clk`  in  1  clock.
- `reset`  in  1  reset, synchronous, active-high.
- `v1`  in  32  rs operand, already forwarded.
- `v2`  in  32  rt operand, already forwarded.
- `opt`  in  3  000 mult, 001 multu, 010 div, 011 divu, 100 mthi, 101 mtlo, 110 madd, 111 msub.
- `start`  in  1  one-cycle operation request; `opt`, `v1`, `v2` are sampled with it.
- `busy`  out  1  high while a mult/div is in flight.
- `hi`  out  32  architectural HI.
- `lo`  out  32  architectural LO.

## Operation
- Reset: `busy`=0, `hi`=0, `lo`=0, cycle counter=0, pending result discarded.
- States: IDLE, RUN. IDLE + `start` + mult-class/div-class opt → RUN; operands and opt latched; counter loaded with MULT_CYCLES or DIV_CYCLES. RUN decrements the counter each cycle; at counter==1 the result commits to HI/LO and the state returns to IDLE.
- mult: {hi,lo} = signed(v1)*signed(v2), 64-bit. multu: the same, unsigned.
- div: lo = quotient truncated toward zero, hi = remainder with the sign of the dividend. divu: unsigned. 0x80000000 div 0xFFFFFFFF → lo=0x80000000, hi=0.
- Divisor zero (div/divu): busy for DIV_CYCLES as normal; HI/LO unchanged at commit.
- mthi/mtlo: `hi`←v1 or `lo`←v1 at the sampling edge. `busy` is never asserted. Accepted only in IDLE.
- `start` while RUN: ignored; no state or HI/LO change. The hazard unit makes this unreachable; the unit still tolerates it.
- `hi`/`lo` always show the committed architectural values. Intermediate results are never visible.

## Timing
- `start` high in cycle T (sampled at the end of T): `busy` is high in cycles T+1 … T+N (N = MULT_CYCLES or DIV_CYCLES). The new `hi`/`lo` are visible from cycle T+N+1, in which `busy`=0.
- `start`+mthi/mtlo in cycle T: the new value is visible in cycle T+1.
- A new `start` is accepted in cycle T+N+1, giving back-to-back ops with no bubble beyond `busy`.
- Reset asserted in any cycle, including mid-RUN: the next cycle shows the reset values.
- `busy` is a registered output. `hi`/`lo` are registered.

## Configuration
- `MD_ACC_EN` defined: opt 110 madd → {hi,lo} += signed(v1)*signed(v2). opt 111 msub → {hi,lo} -= signed(v1)*signed(v2). Both are mult-class with MULT_CYCLES latency. The accumulation uses the {hi,lo} value at commit time and wraps modulo 2^64.
- `MD_ACC_EN` undefined: opt 110/111 with `start` are treated as no-ops: no busy and no HI/LO change.

## Structure
- Package `md_pkg` holds:
  - the `md_opt_e` enum for the 3-bit opt encoding;
  - the default latency constants `MD_MULT_CYCLES`=5 and `MD_DIV_CYCLES`=10;
  - the state enum `md_state_e` {IDLE, RUN}.
- One sub-module, `md_divider`: combinational signed/unsigned 32-bit divide of the latched operands. Outputs are quotient, remainder and `div_zero`. The top-level module holds the FSM, counter, operand latches and HI/LO.

## Test plan
- mult: v1=0xFFFFFFFE (-2), v2=3, start at T → busy in T+1..T+5; at T+6 hi=0xFFFFFFFF, lo=0xFFFFFFFA, busy=0.
- multu: same operands → hi=0x00000002, lo=0xFFFFFFFA at T+6. divu: 7/2 → lo=3, hi=1 at T+11.
- div: v1=-7 (0xFFFFFFF9), v2=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF at T+11. Then div by 0 with prior hi=0xFFFFFFFF, lo=0xFFFFFFFD → busy 10 cycles, then hi/lo unchanged.
- mthi 0x12345678, then mtlo 0x9ABCDEF0 on consecutive cycles → busy stays 0; hi/lo update one cycle after each start.
- mult running, second start (divu) at T+2 → ignored; the mult result commits at T+6 and busy=0 at T+6. Reset at T+3 of a div → hi=lo=0 and busy=0 next cycle, with no later commit.
- With `MD_ACC_EN`: hi=0, lo=0xFFFFFFFF, madd 1×1 → hi=1, lo=0 after 5 busy cycles. Then msub 1×1 → hi=0, lo=0xFFFFFFFF. Without the macro, opt 110 leaves hi=1/lo=0 and busy=0.
